// File: rtl/heating_controller_if.sv
// Sensor-side inputs and heater-side status of the heating controller, bundled as one interface.
interface heating_controller_if #(
   parameter int TEMP_W = 8
);
   logic              tick;
   logic [TEMP_W-1:0] temp;
   logic [TEMP_W-1:0] setpoint;
   logic              presence;
   logic              window;
   logic              ac_cool;
   logic              heat_on;
   logic [1:0]        state;
   logic              inhibit;
   logic [7:0]        heat_starts;

   modport master (
      output tick, temp, setpoint, presence, window, ac_cool,
      input  heat_on, state, inhibit, heat_starts
   );

   modport slave (
      input  tick, temp, setpoint, presence, window, ac_cool,
      output heat_on, state, inhibit, heat_starts
   );
endinterface

// File: rtl/heating_controller.sv
// Room heater sequencer: hysteresis, min on/off times, vacancy hold-off, window/AC interlock.
// Optional frost protection while unoccupied is enabled by defining FROST_PROTECT_EN.
module heating_controller #(
   parameter int TEMP_W        = 8,
   parameter int HYST          = 2,
   parameter int MIN_ON_TICKS  = 5,
   parameter int MIN_OFF_TICKS = 3,
   parameter int VACANCY_TICKS = 10,
   parameter int FROST_TEMP    = 8
) (
   input logic clk,
   input logic rst,
   heating_controller_if.slave hc
);
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      HEATING = 2'b01,
      LOCKOUT = 2'b10
   } state_t;

`ifdef FROST_PROTECT_EN
   localparam bit FROST_EN = 1'b1;
`else
   localparam bit FROST_EN = 1'b0;
`endif

   localparam int ON_W  = $clog2(MIN_ON_TICKS + 2);
   localparam int OFF_W = $clog2(MIN_OFF_TICKS + 2);
   localparam int VAC_W = $clog2(VACANCY_TICKS + 2);
   localparam int TW1   = TEMP_W + 1;

   localparam logic [ON_W-1:0]   ON_INIT   = ON_W'(MIN_ON_TICKS);
   localparam logic [OFF_W-1:0]  OFF_INIT  = OFF_W'(MIN_OFF_TICKS);
   localparam logic [VAC_W-1:0]  VAC_INIT  = VAC_W'(VACANCY_TICKS);
   localparam logic [ON_W-1:0]   ON_ONE    = ON_W'(1);
   localparam logic [OFF_W-1:0]  OFF_ONE   = OFF_W'(1);
   localparam logic [VAC_W-1:0]  VAC_ONE   = VAC_W'(1);
   localparam logic [TEMP_W-1:0] HYST_T    = TEMP_W'(HYST);
   localparam logic [TW1-1:0]    FROST_ON  = TW1'(FROST_TEMP);
   localparam logic [TW1-1:0]    FROST_OFF = TW1'(FROST_TEMP + HYST);

   state_t            st;
   logic              heat_on_q;
   logic              inhibit_q;
   logic [7:0]        starts_q;
   logic [ON_W-1:0]   on_timer;
   logic [OFF_W-1:0]  off_timer;
   logic [VAC_W-1:0]  vac_timer;

   logic              interlock;
   logic              occupied;
   logic [TEMP_W-1:0] on_thr;
   logic              occ_demand;
   logic              frost_demand;
   logic              demand;
   logic              heat_done;

   // on_thr saturates at 0 so a tiny setpoint never wraps into a huge threshold
   assign on_thr       = (hc.setpoint >= HYST_T) ? (hc.setpoint - HYST_T) : '0;
   assign interlock    = hc.window | hc.ac_cool;
   assign occupied     = hc.presence | (vac_timer != '0);
   assign occ_demand   = occupied & (hc.temp < on_thr);
   assign frost_demand = FROST_EN & ~occupied & ({1'b0, hc.temp} < FROST_ON);
   assign demand       = (occ_demand | frost_demand) & ~interlock;
   assign heat_done    = occupied ? (hc.temp >= hc.setpoint)
                                  : (FROST_EN ? ({1'b0, hc.temp} >= FROST_OFF) : 1'b1);

   always_ff @(posedge clk) begin
      if (rst)
         vac_timer <= '0;
      else if (hc.presence)
         vac_timer <= VAC_INIT;
      else if (hc.tick && vac_timer != '0)
         vac_timer <= vac_timer - VAC_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= IDLE;
         heat_on_q <= 1'b0;
         inhibit_q <= 1'b0;
         starts_q  <= 8'd0;
         on_timer  <= '0;
         off_timer <= '0;
      end else begin
         inhibit_q <= interlock;
         case (st)
            IDLE: begin
               if (demand) begin
                  st        <= HEATING;
                  heat_on_q <= 1'b1;
                  on_timer  <= ON_INIT;
                  starts_q  <= starts_q + 8'd1;
               end
            end
            HEATING: begin
               // interlock overrides the minimum on time
               if (interlock || (on_timer == '0 && heat_done)) begin
                  st        <= LOCKOUT;
                  heat_on_q <= 1'b0;
                  off_timer <= OFF_INIT;
               end else if (hc.tick && on_timer != '0) begin
                  on_timer <= on_timer - ON_ONE;
               end
            end
            LOCKOUT: begin
               if (off_timer == '0)
                  st <= IDLE;
               else if (hc.tick)
                  off_timer <= off_timer - OFF_ONE;
            end
            default: begin
               st        <= IDLE;
               heat_on_q <= 1'b0;
            end
         endcase
      end
   end

   assign hc.heat_on     = heat_on_q;
   assign hc.state       = st;
   assign hc.inhibit     = inhibit_q;
   assign hc.heat_starts = starts_q;
endmodule
